// File: rtl/fmrv32im_axil_slave_ram.sv
// rtl/fmrv32im_axil_slave_ram.sv - AXI4-Lite responder: byte-strobed RAM, wait states, test mailbox
//
// Slave end of the core's IM_AXI peripheral port. It provides a word-addressed RAM,
// a programmable response latency and a mailbox register that pass/fail programs
// write their result to.
//
// Ports:
//   RST_N, CLK            asynchronous active-low reset, rising-edge clock
//   S_AXI_AW*             write address channel (CACHE/PROT ignored)
//   S_AXI_W*              write data channel, WSTRB bit i enables WDATA[8i+7:8i]
//   S_AXI_B*              write response channel
//   S_AXI_AR*             read address channel (CACHE/PROT ignored)
//   S_AXI_R*              read data channel
//   TEST_DONE             sticky flag, set by a full-word mailbox write
//   TEST_RESULT           last full-word value written to the mailbox
module fmrv32im_axil_slave_ram #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    MEM_WORDS    = 1024,
  parameter int                    WAIT_CYCLES  = 0,
  parameter logic [ADDR_WIDTH-1:0] MAILBOX_ADDR = 16'hF000
) (
  input  logic                  RST_N,
  input  logic                  CLK,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [3:0]            S_AXI_AWCACHE,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [1:0]            S_AXI_BRESP,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [3:0]            S_AXI_ARCACHE,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  TEST_DONE,
  output logic [31:0]           TEST_RESULT
);

  localparam int                  IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_WORDS);
  // Writes enter W_WAIT one edge after both halves are held, so they load one less.
  localparam logic [3:0]          W_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  // Reads always pass through R_WAIT, so the full count is loaded at AR acceptance.
  localparam logic [3:0]          R_LOAD    = 4'(WAIT_CYCLES);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic is_ram(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < RAM_BYTES;
  endfunction

  function automatic logic is_mbox(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2] == MAILBOX_ADDR[ADDR_WIDTH-1:2];
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT};

  // ---------------------------------------------------------------- write path
  w_state_t              w_state, w_state_n;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [3:0]            w_cnt;
  logic                  w_commit, w_cnt_load, b_hs, aw_hs, w_hs;

  // READYs are gated by RST_N so they stay low while reset is asserted.
  assign S_AXI_AWREADY = RST_N && (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = RST_N && (w_state == W_IDLE) && !w_held;
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs          = S_AXI_BVALID && S_AXI_BREADY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) w_state <= W_IDLE;
    else        w_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = w_state;
    w_commit   = 1'b0;
    w_cnt_load = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          if (WAIT_CYCLES > 0) begin
            w_cnt_load = 1'b1;
            w_state_n  = W_WAIT;
          end else begin
            w_commit  = 1'b1;
            w_state_n = W_RESP;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == 4'd0) begin
          w_commit  = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      w_cnt        <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      TEST_DONE    <= 1'b0;
      TEST_RESULT  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (w_cnt_load)                           w_cnt <= W_LOAD;
      else if (w_state == W_WAIT && w_cnt != 0) w_cnt <= w_cnt - 4'd1;
      if (w_commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (is_ram(awaddr_q) || is_mbox(awaddr_q)) ? RESP_OKAY : RESP_SLVERR;
        // A partial-strobe mailbox write is acknowledged but deliberately ignored.
        if (is_mbox(awaddr_q) && wstrb_q == 4'hF) begin
          TEST_DONE   <= 1'b1;
          TEST_RESULT <= wdata_q;
        end
      end
      if (w_state == W_RESP && b_hs) begin
        S_AXI_BVALID <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  // RAM array is not reset; w_commit cannot fire while reset holds the FSM idle.
  always_ff @(posedge CLK) begin
    if (w_commit && is_ram(awaddr_q)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[awaddr_q[IDX_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t              r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [3:0]            r_cnt;
  logic                  r_load, ar_hs;

  assign S_AXI_ARREADY = RST_N && (r_state == R_IDLE);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= R_IDLE;
    else        r_state <= r_state_n;
  end

  always_comb begin
    r_state_n = r_state;
    r_load    = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_WAIT;
      R_WAIT: begin
        if (r_cnt == 4'd0) begin
          r_load    = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: if (S_AXI_RREADY) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // RAM is sampled with the pre-edge contents, so a write committing on the same
  // edge to the same word is not visible to this read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      araddr_q     <= '0;
      r_cnt        <= '0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        araddr_q <= S_AXI_ARADDR;
        r_cnt    <= R_LOAD;
      end else if (r_state == R_WAIT && r_cnt != 0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_load) begin
        S_AXI_RVALID <= 1'b1;
        if (is_ram(araddr_q)) begin
          S_AXI_RDATA <= mem[araddr_q[IDX_W+1:2]];
          S_AXI_RRESP <= RESP_OKAY;
        end else if (is_mbox(araddr_q)) begin
          S_AXI_RDATA <= TEST_RESULT;
          S_AXI_RRESP <= RESP_OKAY;
        end else begin
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_SLVERR;
        end
      end
      if (r_state == R_DATA && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmrv32im_axil_slave_ram.sv
// tb/tb_fmrv32im_axil_slave_ram.sv - directed bench for fmrv32im_axil_slave_ram
module tb_fmrv32im_axil_slave_ram;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // instance a: WAIT_CYCLES=0
  logic [15:0] a_awaddr, a_araddr;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready, a_done;
  logic [31:0] a_wdata, a_rdata, a_result;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_bresp, a_rresp;

  // instance b: WAIT_CYCLES=3
  logic [15:0] b_awaddr, b_araddr;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_done;
  logic [31:0] b_wdata, b_rdata, b_result;
  logic [3:0]  b_wstrb;
  logic [1:0]  b_bresp, b_rresp;

  fmrv32im_axil_slave_ram #(.WAIT_CYCLES(0)) dut0 (
    .RST_N(RST_N), .CLK(CLK),
    .S_AXI_AWADDR(a_awaddr), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0),
    .S_AXI_AWVALID(a_awvalid), .S_AXI_AWREADY(a_awready),
    .S_AXI_WDATA(a_wdata), .S_AXI_WSTRB(a_wstrb), .S_AXI_WVALID(a_wvalid), .S_AXI_WREADY(a_wready),
    .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(a_bready), .S_AXI_BRESP(a_bresp),
    .S_AXI_ARADDR(a_araddr), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
    .S_AXI_ARVALID(a_arvalid), .S_AXI_ARREADY(a_arready),
    .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(a_rready),
    .TEST_DONE(a_done), .TEST_RESULT(a_result)
  );

  fmrv32im_axil_slave_ram #(.WAIT_CYCLES(3)) dut3 (
    .RST_N(RST_N), .CLK(CLK),
    .S_AXI_AWADDR(b_awaddr), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0),
    .S_AXI_AWVALID(b_awvalid), .S_AXI_AWREADY(b_awready),
    .S_AXI_WDATA(b_wdata), .S_AXI_WSTRB(b_wstrb), .S_AXI_WVALID(b_wvalid), .S_AXI_WREADY(b_wready),
    .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(b_bready), .S_AXI_BRESP(b_bresp),
    .S_AXI_ARADDR(b_araddr), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
    .S_AXI_ARVALID(b_arvalid), .S_AXI_ARREADY(b_arready),
    .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(b_rready),
    .TEST_DONE(b_done), .TEST_RESULT(b_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Full write on instance a, BREADY held high; returns BRESP.
  task automatic wr_a(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
    logic aw_done, w_done;
    int n;
    a_awaddr = a; a_awvalid = 1'b1; a_wdata = d; a_wstrb = s; a_wvalid = 1'b1; a_bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (a_awvalid && a_awready) aw_done = 1'b1;
      if (a_wvalid && a_wready)   w_done  = 1'b1;
      step();
      if (aw_done) a_awvalid = 1'b0;
      if (w_done)  a_wvalid  = 1'b0;
      n++;
    end
    n = 0;
    while (!a_bvalid && n < 20) begin step(); n++; end
    chk("wr_bvalid_seen", {31'd0, a_bvalid}, 32'd1);
    resp = a_bresp;
    step();
    a_bready = 1'b0;
  endtask

  // Full read on instance a, RREADY held high; returns RDATA/RRESP.
  task automatic rd_a(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    a_araddr = a; a_arvalid = 1'b1; a_rready = 1'b1;
    step();
    a_arvalid = 1'b0;
    n = 0;
    while (!a_rvalid && n < 20) begin step(); n++; end
    chk("rd_rvalid_seen", {31'd0, a_rvalid}, 32'd1);
    d = a_rdata; resp = a_rresp;
    step();
    a_rready = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    RST_N = 1'b0;
    a_awaddr = 0; a_awvalid = 0; a_wdata = 0; a_wstrb = 0; a_wvalid = 0; a_bready = 0;
    a_araddr = 0; a_arvalid = 0; a_rready = 0;
    b_awaddr = 0; b_awvalid = 0; b_wdata = 0; b_wstrb = 0; b_wvalid = 0; b_bready = 0;
    b_araddr = 0; b_arvalid = 0; b_rready = 0;
    repeat (3) step();

    // reset state
    chk("rst_awready", {31'd0, a_awready}, 32'd0);
    chk("rst_wready",  {31'd0, a_wready},  32'd0);
    chk("rst_arready", {31'd0, a_arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, a_bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, a_rvalid},  32'd0);
    chk("rst_rdata",   a_rdata,            32'd0);
    chk("rst_done",    {31'd0, a_done},    32'd0);
    chk("rst_result",  a_result,           32'd0);
    RST_N = 1'b1;
    #1;
    chk("post_rst_awready", {31'd0, a_awready}, 32'd1);
    chk("post_rst_arready", {31'd0, a_arready}, 32'd1);

    // AW+W same cycle, response latency
    a_awaddr = 16'h0010; a_awvalid = 1; a_wdata = 32'hDEADBEEF; a_wstrb = 4'hF; a_wvalid = 1;
    a_bready = 1;
    step();
    a_awvalid = 0; a_wvalid = 0;
    chk("t1_bvalid_n",   {31'd0, a_bvalid},  32'd0);
    chk("t1_awready_n",  {31'd0, a_awready}, 32'd0);
    step();
    chk("t1_bvalid_n1",  {31'd0, a_bvalid},  32'd1);
    chk("t1_bresp",      {30'd0, a_bresp},   32'd0);
    step();
    a_bready = 0;
    chk("t1_bvalid_done", {31'd0, a_bvalid}, 32'd0);
    chk("t1_awready_back", {31'd0, a_awready}, 32'd1);

    // read back, latency and ARREADY low while data is pending
    a_araddr = 16'h0010; a_arvalid = 1; a_rready = 1;
    step();
    a_arvalid = 0;
    chk("t1_rvalid_n", {31'd0, a_rvalid}, 32'd0);
    step();
    chk("t1_rvalid_n1", {31'd0, a_rvalid},  32'd1);
    chk("t1_rdata",     a_rdata,            32'hDEADBEEF);
    chk("t1_rresp",     {30'd0, a_rresp},   32'd0);
    chk("t1_arready_busy", {31'd0, a_arready}, 32'd0);
    step();
    a_rready = 0;
    chk("t1_rvalid_done", {31'd0, a_rvalid}, 32'd0);

    // byte strobes
    wr_a(16'h0020, 32'h11223344, 4'hF, r);
    wr_a(16'h0020, 32'hAABBCCDD, 4'b0101, r);
    chk("strb_bresp", {30'd0, r}, 32'd0);
    rd_a(16'h0020, d, r);
    chk("strb_rdata", d, 32'h11BB33DD);

    // W three cycles ahead of AW, BREADY low for five cycles
    a_wdata = 32'h55667788; a_wstrb = 4'hF; a_wvalid = 1; a_bready = 0;
    step();
    a_wvalid = 0;
    chk("wfirst_wready_drop", {31'd0, a_wready},  32'd0);
    chk("wfirst_awready",     {31'd0, a_awready}, 32'd1);
    step();
    step();
    a_awaddr = 16'h0030; a_awvalid = 1;
    step();
    a_awvalid = 0;
    chk("wfirst_bvalid_n", {31'd0, a_bvalid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wfirst_bvalid_hold", {31'd0, a_bvalid}, 32'd1);
      chk("wfirst_bresp_hold",  {30'd0, a_bresp},  32'd0);
      chk("wfirst_ready_low",   {30'd0, a_awready, a_wready}, 32'd0);
    end
    a_bready = 1;
    step();
    a_bready = 0;
    chk("wfirst_bvalid_done", {31'd0, a_bvalid}, 32'd0);
    chk("wfirst_ready_back",  {30'd0, a_awready, a_wready}, 32'd3);
    rd_a(16'h0030, d, r);
    chk("wfirst_rdata", d, 32'h55667788);

    // WAIT_CYCLES=3 instance: write then read with counted latency
    b_awaddr = 16'h0004; b_awvalid = 1; b_wdata = 32'hC0FFEE04; b_wstrb = 4'hF; b_wvalid = 1;
    b_bready = 1;
    step();
    b_awvalid = 0; b_wvalid = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("w3_bvalid_timing", {31'd0, b_bvalid}, (i == 4) ? 32'd1 : 32'd0);
    end
    step();
    b_bready = 0;
    chk("w3_bvalid_done", {31'd0, b_bvalid}, 32'd0);
    b_araddr = 16'h0004; b_arvalid = 1; b_rready = 0;
    step();
    b_arvalid = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("w3_rvalid_timing", {31'd0, b_rvalid}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("w3_rdata", b_rdata, 32'hC0FFEE04);
    chk("w3_rresp", {30'd0, b_rresp}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("w3_rvalid_hold", {31'd0, b_rvalid}, 32'd1);
      chk("w3_rdata_hold",  b_rdata,           32'hC0FFEE04);
    end
    b_rready = 1;
    step();
    b_rready = 0;
    chk("w3_rvalid_done", {31'd0, b_rvalid}, 32'd0);

    // out-of-range: aliases word 0 in the index bits, must not disturb it
    wr_a(16'h0000, 32'h0BADC0DE, 4'hF, r);
    wr_a(16'h2000, 32'hCAFEF00D, 4'hF, r);
    chk("oor_bresp", {30'd0, r}, 32'd2);
    rd_a(16'h0000, d, r);
    chk("oor_ram_unchanged", d, 32'h0BADC0DE);
    rd_a(16'h2000, d, r);
    chk("oor_rdata", d, 32'd0);
    chk("oor_rresp", {30'd0, r}, 32'd2);

    // mailbox
    wr_a(16'hF000, 32'h00000001, 4'hF, r);
    chk("mbox_bresp",  {30'd0, r},      32'd0);
    chk("mbox_done",   {31'd0, a_done}, 32'd1);
    chk("mbox_result", a_result,        32'd1);
    wr_a(16'hF000, 32'h12345678, 4'h3, r);
    chk("mbox_part_bresp",  {30'd0, r}, 32'd0);
    chk("mbox_part_result", a_result,   32'd1);
    rd_a(16'hF000, d, r);
    chk("mbox_rdata", d, 32'd1);
    wr_a(16'hF000, 32'h00000ABC, 4'hF, r);
    chk("mbox_overwrite", a_result,        32'h00000ABC);
    chk("mbox_done_kept", {31'd0, a_done}, 32'd1);

    // reset in the middle of a read
    a_araddr = 16'h0010; a_arvalid = 1; a_rready = 0;
    step();
    a_arvalid = 0;
    step();
    chk("midrd_rvalid_pre", {31'd0, a_rvalid}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midrd_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("midrd_done",   {31'd0, a_done},   32'd0);
    chk("midrd_result", a_result,          32'd0);
    chk("midrd_rdata",  a_rdata,           32'd0);
    step();
    RST_N = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmrv32im_axil_slave_ram.md
Name: fmrv32im_axil_slave_ram

Overview:
Synthesizable AXI4-Lite responder, the slave end of the core's IM_AXI peripheral master port (16-bit address, 32-bit data).
- Provides a word-addressed RAM with byte strobes, a programmable wait-state latency, and a test mailbox register.
- Lets the core run pass/fail programs on FPGA and in simulation without a behavioural slave model.

Parameters:
ADDR_WIDTH, 16, AXI address width
MEM_WORDS, 1024, RAM depth in 32-bit words (power of 2); RAM decodes 0x0000 .. 4*MEM_WORDS-1
WAIT_CYCLES, 0, extra cycles between address/data acceptance and response (0..15)
MAILBOX_ADDR, 16'hF000, word address of test mailbox (outside RAM range)

Ports:
RST_N  in  1  asynchronous active-low reset
CLK  in  1  clock, all logic on rising edge
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWCACHE  in  4  ignored
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables, bit i -> WDATA[8i+7:8i]
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_BRESP  out  2  write response
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARCACHE  in  4  ignored
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
TEST_DONE  out  1  sticky, set by full-word mailbox write
TEST_RESULT  out  32  last full-word value written to mailbox

Behaviour:
- Reset (RST_N=0, async): all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, TEST_DONE 0, TEST_RESULT 0, both FSMs idle, latched AW/W flags cleared. RAM contents not reset.
- READYs assert in the first cycle after RST_N rises.
- Reset mid-transaction aborts it; no RAM or mailbox update unless the commit edge has already passed.
- Decode, word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored:
  - addr < 4*MEM_WORDS: RAM, resp OKAY (2'b00).
  - addr == MAILBOX_ADDR: mailbox, resp OKAY.
  - otherwise: SLVERR (2'b10); writes dropped, reads return 32'h0.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AWREADY = !aw_held, WREADY = !w_held. AW and W are accepted independently, in either order or the same cycle.
  - Once both are held: go to W_WAIT if WAIT_CYCLES>0, else commit immediately.
  - W_WAIT: counter loads WAIT_CYCLES-1 and decrements; commit when it reaches 0.
  - Commit edge: update RAM bytes where WSTRB=1; enter W_RESP with BVALID=1 and BRESP set.
  - W_RESP: BVALID and BRESP held stable until BREADY. On handshake: BVALID=0, held flags cleared, return to W_IDLE. READYs reassert the next cycle.
  - Latency, WAIT_CYCLES=0: last of AW/W accepted at edge N -> BVALID high after edge N+1.
- Mailbox write: WSTRB==4'hF sets TEST_DONE=1 and TEST_RESULT=WDATA at commit. A partial strobe is ignored but returns OKAY. TEST_DONE stays set until reset; later full writes overwrite TEST_RESULT.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: ARREADY=1; handshake latches address.
  - R_WAIT: counts WAIT_CYCLES as for writes.
  - Entry to R_DATA: RDATA and RRESP registered, RVALID=1. Mailbox read returns TEST_RESULT.
  - R_DATA: RDATA, RRESP and RVALID held stable until RREADY, then return to R_IDLE with ARREADY=0 that cycle.
  - Latency, WAIT_CYCLES=0: AR accepted at edge N -> RVALID after edge N+1.
- Read and write channels are fully independent and may be active simultaneously.
- Same-address collision: if a write commits on the same edge the read samples RAM, the read returns the old data.
- No outstanding-transaction queueing: at most one write and one read in flight.

Test Plan:
- WAIT_CYCLES=0; AW 0x0010 and W 0xDEADBEEF (WSTRB F) in the same cycle, BREADY=1 -> BVALID one cycle after handshake, BRESP=00. Then AR 0x0010 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after AR.
- Byte strobes: write 0x11223344 STRB F to 0x0020, then 0xAABBCCDD STRB 4'b0101 -> readback 0x11BB33DD.
- W presented 3 cycles before AW with BREADY held low 5 cycles -> WREADY drops after W accept, BVALID/BRESP stable 5 cycles, AWREADY/WREADY high again the cycle after BREADY.
- WAIT_CYCLES=3: read of 0x0004 -> RVALID exactly 4 cycles after AR handshake. RREADY low 2 cycles -> RDATA stable.
- Out of range: write 0x2000 -> BRESP=10, RAM unchanged. Read 0x2000 -> RDATA=0, RRESP=10.
- Mailbox: write 0x00000001 STRB F to 0xF000 -> TEST_DONE=1, TEST_RESULT=1. Write STRB 3 -> no change. Assert RST_N=0 mid-read -> RVALID=0 and TEST_DONE=0 immediately.
